// File: rtl/mul32_if.sv
// rtl/mul32_if.sv - operand/result bundle for the mul32 execution unit
interface mul32_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] C;

  modport master (output A, output B, input C);
  modport slave  (input A, input B, output C);
endinterface

// File: rtl/mul32.sv
// rtl/mul32.sv - registered 32x32 multiplier, low word of the product
// Partial-product array -> 3:2 carry-save tree -> carry-propagate add -> C register.
module mul32 (
  input  logic   clk,
  input  logic   rst_n,
  mul32_if.slave bus
);
  // 32 rows shrink 32->22->15->10->7->5->4->3->2 across eight 3:2 levels
  localparam int LEVELS = 8;

  logic [31:0] sum_vec;
  logic [31:0] carry_vec;
  logic [31:0] prod;

  always_comb begin : csa_tree
    logic [31:0] row [0:LEVELS][0:31];
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    int n;
    int groups;
    int rem;

    for (int l = 0; l <= LEVELS; l++) begin
      for (int i = 0; i < 32; i++) begin
        row[l][i] = 32'd0;
      end
    end
    x      = 32'd0;
    y      = 32'd0;
    z      = 32'd0;
    n      = 32;
    groups = 0;
    rem    = 0;

    for (int i = 0; i < 32; i++) begin
      row[0][i] = bus.B[i] ? (bus.A << i) : 32'd0;
    end

    for (int l = 0; l < LEVELS; l++) begin
      groups = n / 3;
      rem    = n % 3;
      for (int g = 0; g < 10; g++) begin
        if (g < groups) begin
          x = row[l][3*g];
          y = row[l][3*g+1];
          z = row[l][3*g+2];
          row[l+1][2*g]   = x ^ y ^ z;
          // shifting the majority left drops the carry out of bit 31
          row[l+1][2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (r < rem) begin
          row[l+1][2*groups+r] = row[l][3*groups+r];
        end
      end
      n = 2 * groups + rem;
    end

    sum_vec   = row[LEVELS][0];
    carry_vec = row[LEVELS][1];
  end

  assign prod = sum_vec + carry_vec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.C <= 32'd0;
    end else begin
      bus.C <= prod;
    end
  end
endmodule

// File: tb/tb_mul32.sv
// tb/tb_mul32.sv - self-checking bench for mul32
module tb_mul32;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mul32_if bus ();

  mul32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b);
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    errors = 0;
    checks = 0;

    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[1] = '{32'h00010000, 32'h00010000, 32'h00000000};
    vecs[2] = '{32'h12345678, 32'h9ABCDEF0, 32'h242D2080};
    vecs[3] = '{32'h00000000, 32'hDEADBEEF, 32'h00000000};
    vecs[4] = '{32'h00000001, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[5] = '{32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFB};
    vecs[6] = '{32'h80000000, 32'h00000002, 32'h00000000};
    vecs[7] = '{32'hDEADBEEF, 32'h00000000, 32'h00000000};
    vecs[8] = '{32'h00000003, 32'h00000007, 32'h00000015};
    vecs[9] = '{32'h0000000A, 32'h0000000A, 32'h00000064};

    // reset held for two edges with live operands
    rst_n = 1'b0;
    bus.A = 32'd5;
    bus.B = 32'd7;
    @(posedge clk);
    #1;
    check("reset_edge1", bus.C, 32'd0);
    @(posedge clk);
    #1;
    check("reset_edge2", bus.C, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", bus.C, 32'd35);

    for (int k = 0; k < 10; k++) begin
      apply(vecs[k].a, vecs[k].b);
      check($sformatf("vec%0d", k), bus.C, vecs[k].exp);
    end

    for (int i = 1; i <= 10; i++) begin
      for (int j = 1; j <= 10; j++) begin
        apply(32'(i), 32'(j));
        check($sformatf("sweep_%0dx%0d", i, j), bus.C, 32'(i * j));
      end
    end

    // operands changing between edges must not disturb C
    apply(32'd6, 32'd9);
    bus.A = 32'd1000;
    bus.B = 32'd1000;
    #3;
    check("hold_between_edges", bus.C, 32'd54);
    @(posedge clk);
    #1;
    check("after_hold_edge", bus.C, 32'd1000000);

    for (int k = 0; k < 1000; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (k % 50 == 0) ra = 32'hFFFFFFFF;
      if (k % 77 == 0) rb = 32'h80000000;
      apply(ra, rb);
      check($sformatf("rand%0d", k), bus.C, model(ra, rb));
    end

    // mid-stream reset discards the in-flight product
    apply(32'd3, 32'd4);
    check("midstream_pre", bus.C, 32'd12);
    bus.A = 32'd3;
    bus.B = 32'd4;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midstream_reset", bus.C, 32'd0);
    rst_n = 1'b1;
    apply(32'hFFFF0001, 32'h00010001);
    check("post_reset", bus.C, model(32'hFFFF0001, 32'h00010001));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
